ex_mem: RTL and testbench
=========================

# ex_mem

EX/MEM pipeline stage of the five-stage MIPS datapath: registers the execute-stage results, drives the data-cache request for loads and stores, and waits for `dhit`. It presents exactly one valid copy of each retiring instruction to `mem_wrb`, which samples unconditionally every cycle. While a memory access is outstanding, it drives bubble control outputs.

## Interface
Parameters:
- none; widths come from `cpu_types_pkg` (`word_t` 32, `regbits_t` 5, `opcode_t` 6, `funct_t` 6).

Ports (one clock; reset is synchronous and active-high):
- `CLK` in 1: rising-edge clock.
- `RST` in 1: synchronous active-high reset.
- `en` in 1: hazard unit permits the stage to accept a new instruction.
- `flush` in 1: load a bubble instead of the incoming instruction.
- `instr_in`, `pc_in`, `pcplusfour_in`, `alu_portOut_in`, `rdat2_in` in 32 each: EX results.
- `imm_addr_in` in 16: immediate field.
- `wsel_in`, `shift_amt_in`, `reg_rs_in`, `reg_rt_in` in 5 each: register fields.
- `opcode_in` in `opcode_t`, `funct_in` in `funct_t`.
- `RegWr_in`, `MemtoReg_in`, `MemRead_in`, `MemWrite_in`, `jal_s_in`, `lui_in`, `halt_in` in 1 each: control signals.
- `dhit` in 1: data cache completes the access this cycle.
- `dmemload` in 32: load data, valid when `dhit` is high.
- `dmemREN`, `dmemWEN` out 1 each: cache read and write requests.
- `dmemaddr`, `dmemstore` out 32 each: cache address and store data.
- `stall_for_data` out 1: memory access outstanding; the hazard unit freezes IF/ID/EX.
- `*_out` out, same widths as the matching `*_in` (`MemRead`/`MemWrite` excluded): fields passed to `mem_wrb`.
- `wdat_out` out 32: `dmemload` when the instruction is a load, else `alu_portOut`.

## Operation
- Fields are held in registers `*_q`. The state register `st` takes the values EMPTY, WAIT and VALID.
- Latch condition: `ld = en & ~stall_for_data`. On `ld`:
  - If `flush` is high, the state goes to EMPTY and the control bits in `*_q` clear.
  - Otherwise all `*_q` take the `*_in` values. The state goes to WAIT if `MemRead_in | MemWrite_in`, else to VALID.
- Transitions without `ld`:
  - WAIT with `dhit` → EMPTY.
  - WAIT without `dhit` → WAIT.
  - VALID → EMPTY.
  - EMPTY → EMPTY.
- `dmemREN = (st==WAIT) & MemRead_q`. `dmemWEN = (st==WAIT) & MemWrite_q`.
- `dmemaddr = alu_portOut_q`. `dmemstore = rdat2_q`.
- `stall_for_data = (st==WAIT) & ~dhit`.
- Output valid: `ov = (st==VALID) | ((st==WAIT) & dhit)`.
  - `RegWr_out`, `MemtoReg_out`, `jal_s_out`, `lui_out` and `halt_out` are the `_q` values ANDed with `ov`.
  - Data and field outputs come straight from `_q` and are not gated.
- `wdat_out` is `dmemload` when `MemRead_q` is set, else `alu_portOut_q`.
- `dhit` in EMPTY or VALID is ignored.
- A flush arriving while `stall_for_data` is high is ignored: an outstanding access always completes.
- `ld` and `dhit` in the same cycle in WAIT: the current instruction retires this cycle and the new one is latched at the edge.

## Timing
- Reset: `st` = EMPTY and every `*_q` is 0, so every output is 0 in the cycle after `RST`. This includes `dmemREN`, `dmemWEN` and `stall_for_data`.
- `RST` asserted during WAIT drops the request on the next edge, with no retirement.
- A non-memory instruction is visible to `mem_wrb` for exactly one cycle, the cycle after it is latched.
- Memory instruction:
  - The request is asserted from the cycle after the latch until `dhit` is seen, inclusive.
  - Latency is 1 + (cycles waiting for `dhit`).
  - The instruction retires in the `dhit` cycle.
- If `en` stays low, the stage shows VALID for one cycle and then EMPTY, so there are no duplicate write-backs.
- The path `dhit` → `stall_for_data`/`ov` is combinational, as is `dmemload` → `wdat_out`.

## Structure
- Add `exmem_state_t` (EMPTY, WAIT, VALID; 2 bits) to `cpu_types_pkg`. `word_t`, `regbits_t`, `opcode_t` and `funct_t` already live there.
- Single module, no sub-module. Add an `ex_mem_if.vh` interface with modports `em` (block) and `tb`.

## Test plan
- Reset: assert `RST` with random inputs → next cycle all outputs are 0 and `st` = EMPTY.
- ALU op: latch `addu` (`RegWr_in`=1, `alu_portOut_in`=0x0000_0010) with `en`=1, then `en`=0 for 3 cycles → `RegWr_out`=1 and `wdat_out`=0x10 for exactly 1 cycle, then 0.
- Load with a 3-cycle miss: `lw`, `alu_portOut_in`=0x0000_0100, `dhit` high on the 3rd request cycle, `dmemload`=0xDEAD_BEEF:
  - `dmemREN`=1 and `dmemaddr`=0x100 for 3 cycles.
  - `stall_for_data`=1 for 2 cycles.
  - `RegWr_out`=1 and `wdat_out`=0xDEADBEEF only in the `dhit` cycle.
- Store with `dhit` immediate: `sw`, `rdat2_in`=0x1234_5678 → `dmemWEN`=1 and `dmemstore`=0x12345678 for 1 cycle, `stall_for_data`=0, `RegWr_out`=0.
- Flush and simultaneous events:
  - `flush`=1 with `ld` → next cycle is a bubble.
  - `flush`=1 during WAIT (no `dhit`) → ignored; the request persists.
  - `dhit` and `ld` in the same cycle → old instruction retires and the new one is latched with no gap.
- Reset mid-access: `RST` during WAIT → `dmemREN`=0 next cycle, and no retirement is seen at `RegWr_out`.

Source files
------------

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_types_pkg
// Brief   : Shared datapath types for the five-stage MIPS pipeline.
// Revision: 1.0  initial release
// ============================================================================
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;
  typedef logic [5:0]        opcode_t;
  typedef logic [5:0]        funct_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } exmem_state_t;

endpackage
`default_nettype wire

// File: rtl/ex_mem_if.sv
`default_nettype none
// ============================================================================
// Module  : ex_mem_if
// Brief   : Signal bundle between EX results, the data cache and mem_wrb.
// Revision: 1.0  initial release
// ============================================================================
interface ex_mem_if;
  import cpu_types_pkg::*;

  logic        en;
  logic        flush;
  word_t       instr_in;
  word_t       pc_in;
  word_t       pcplusfour_in;
  word_t       alu_portOut_in;
  word_t       rdat2_in;
  logic [15:0] imm_addr_in;
  regbits_t    wsel_in;
  regbits_t    shift_amt_in;
  regbits_t    reg_rs_in;
  regbits_t    reg_rt_in;
  opcode_t     opcode_in;
  funct_t      funct_in;
  logic        RegWr_in;
  logic        MemtoReg_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic        jal_s_in;
  logic        lui_in;
  logic        halt_in;

  logic        dhit;
  word_t       dmemload;
  logic        dmemREN;
  logic        dmemWEN;
  word_t       dmemaddr;
  word_t       dmemstore;
  logic        stall_for_data;

  word_t       instr_out;
  word_t       pc_out;
  word_t       pcplusfour_out;
  word_t       alu_portOut_out;
  word_t       rdat2_out;
  logic [15:0] imm_addr_out;
  regbits_t    wsel_out;
  regbits_t    shift_amt_out;
  regbits_t    reg_rs_out;
  regbits_t    reg_rt_out;
  opcode_t     opcode_out;
  funct_t      funct_out;
  logic        RegWr_out;
  logic        MemtoReg_out;
  logic        jal_s_out;
  logic        lui_out;
  logic        halt_out;
  word_t       wdat_out;

  modport em (
    input  en, flush, instr_in, pc_in, pcplusfour_in, alu_portOut_in, rdat2_in,
           imm_addr_in, wsel_in, shift_amt_in, reg_rs_in, reg_rt_in, opcode_in,
           funct_in, RegWr_in, MemtoReg_in, MemRead_in, MemWrite_in, jal_s_in,
           lui_in, halt_in, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, stall_for_data,
           instr_out, pc_out, pcplusfour_out, alu_portOut_out, rdat2_out,
           imm_addr_out, wsel_out, shift_amt_out, reg_rs_out, reg_rt_out,
           opcode_out, funct_out, RegWr_out, MemtoReg_out, jal_s_out, lui_out,
           halt_out, wdat_out
  );

  modport tb (
    output en, flush, instr_in, pc_in, pcplusfour_in, alu_portOut_in, rdat2_in,
           imm_addr_in, wsel_in, shift_amt_in, reg_rs_in, reg_rt_in, opcode_in,
           funct_in, RegWr_in, MemtoReg_in, MemRead_in, MemWrite_in, jal_s_in,
           lui_in, halt_in, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, stall_for_data,
           instr_out, pc_out, pcplusfour_out, alu_portOut_out, rdat2_out,
           imm_addr_out, wsel_out, shift_amt_out, reg_rs_out, reg_rt_out,
           opcode_out, funct_out, RegWr_out, MemtoReg_out, jal_s_out, lui_out,
           halt_out, wdat_out
  );

endinterface
`default_nettype wire

// File: rtl/ex_mem.sv
`default_nettype none
// ============================================================================
// Module  : ex_mem
// Brief   : EX/MEM pipeline register; issues D-cache requests and retires each
//           instruction to mem_wrb exactly once.
// Revision: 1.0  initial release
// ============================================================================
module ex_mem
  import cpu_types_pkg::*;
(
  input  wire logic CLK,
  input  wire logic RST,
  ex_mem_if.em      emif
);

  exmem_state_t st, st_next;

  word_t       instr_q, pc_q, pcplusfour_q, alu_portOut_q, rdat2_q;
  logic [15:0] imm_addr_q;
  regbits_t    wsel_q, shift_amt_q, reg_rs_q, reg_rt_q;
  opcode_t     opcode_q;
  funct_t      funct_q;
  logic        RegWr_q, MemtoReg_q, MemRead_q, MemWrite_q, jal_s_q, lui_q, halt_q;

  logic ld;
  logic ov;
  logic in_wait;

  assign in_wait             = (st == WAIT);
  assign emif.stall_for_data = in_wait & ~emif.dhit;
  assign ld                  = emif.en & ~emif.stall_for_data;
  assign ov                  = (st == VALID) | (in_wait & emif.dhit);

  always_ff @(posedge CLK) begin
    if (RST) st <= EMPTY;
    else     st <= st_next;
  end

  always_comb begin
    st_next = st;
    if (ld) begin
      if (emif.flush)                              st_next = EMPTY;
      else if (emif.MemRead_in | emif.MemWrite_in) st_next = WAIT;
      else                                         st_next = VALID;
    end else begin
      case (st)
        WAIT:    st_next = emif.dhit ? EMPTY : WAIT;
        VALID:   st_next = EMPTY;
        default: st_next = EMPTY;
      endcase
    end
  end

  // A flushed bubble only needs its control bits cleared; stale data is harmless.
  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_q       <= '0;
      pc_q          <= '0;
      pcplusfour_q  <= '0;
      alu_portOut_q <= '0;
      rdat2_q       <= '0;
      imm_addr_q    <= '0;
      wsel_q        <= '0;
      shift_amt_q   <= '0;
      reg_rs_q      <= '0;
      reg_rt_q      <= '0;
      opcode_q      <= '0;
      funct_q       <= '0;
      RegWr_q       <= 1'b0;
      MemtoReg_q    <= 1'b0;
      MemRead_q     <= 1'b0;
      MemWrite_q    <= 1'b0;
      jal_s_q       <= 1'b0;
      lui_q         <= 1'b0;
      halt_q        <= 1'b0;
    end else if (ld) begin
      if (emif.flush) begin
        RegWr_q    <= 1'b0;
        MemtoReg_q <= 1'b0;
        MemRead_q  <= 1'b0;
        MemWrite_q <= 1'b0;
        jal_s_q    <= 1'b0;
        lui_q      <= 1'b0;
        halt_q     <= 1'b0;
      end else begin
        instr_q       <= emif.instr_in;
        pc_q          <= emif.pc_in;
        pcplusfour_q  <= emif.pcplusfour_in;
        alu_portOut_q <= emif.alu_portOut_in;
        rdat2_q       <= emif.rdat2_in;
        imm_addr_q    <= emif.imm_addr_in;
        wsel_q        <= emif.wsel_in;
        shift_amt_q   <= emif.shift_amt_in;
        reg_rs_q      <= emif.reg_rs_in;
        reg_rt_q      <= emif.reg_rt_in;
        opcode_q      <= emif.opcode_in;
        funct_q       <= emif.funct_in;
        RegWr_q       <= emif.RegWr_in;
        MemtoReg_q    <= emif.MemtoReg_in;
        MemRead_q     <= emif.MemRead_in;
        MemWrite_q    <= emif.MemWrite_in;
        jal_s_q       <= emif.jal_s_in;
        lui_q         <= emif.lui_in;
        halt_q        <= emif.halt_in;
      end
    end
  end

  assign emif.dmemREN   = in_wait & MemRead_q;
  assign emif.dmemWEN   = in_wait & MemWrite_q;
  assign emif.dmemaddr  = alu_portOut_q;
  assign emif.dmemstore = rdat2_q;

  assign emif.RegWr_out    = RegWr_q    & ov;
  assign emif.MemtoReg_out = MemtoReg_q & ov;
  assign emif.jal_s_out    = jal_s_q    & ov;
  assign emif.lui_out      = lui_q      & ov;
  assign emif.halt_out     = halt_q     & ov;

  assign emif.instr_out       = instr_q;
  assign emif.pc_out          = pc_q;
  assign emif.pcplusfour_out  = pcplusfour_q;
  assign emif.alu_portOut_out = alu_portOut_q;
  assign emif.rdat2_out       = rdat2_q;
  assign emif.imm_addr_out    = imm_addr_q;
  assign emif.wsel_out        = wsel_q;
  assign emif.shift_amt_out   = shift_amt_q;
  assign emif.reg_rs_out      = reg_rs_q;
  assign emif.reg_rt_out      = reg_rt_q;
  assign emif.opcode_out      = opcode_q;
  assign emif.funct_out       = funct_q;
  assign emif.wdat_out        = MemRead_q ? emif.dmemload : alu_portOut_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex_mem
// Brief   : Directed self-checking bench for the EX/MEM pipeline stage.
// Revision: 1.0  initial release
// ============================================================================
module tb_ex_mem;
  import cpu_types_pkg::*;

  logic CLK;
  logic RST;
  int   tests_run;
  int   tests_failed;

  ex_mem_if emif ();

  ex_mem dut (
    .CLK  (CLK),
    .RST  (RST),
    .emif (emif.em)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one edge and let the registered state settle.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    emif.en = 1'b0; emif.flush = 1'b0;
    emif.instr_in = '0; emif.pc_in = '0; emif.pcplusfour_in = '0;
    emif.alu_portOut_in = '0; emif.rdat2_in = '0; emif.imm_addr_in = '0;
    emif.wsel_in = '0; emif.shift_amt_in = '0; emif.reg_rs_in = '0; emif.reg_rt_in = '0;
    emif.opcode_in = '0; emif.funct_in = '0;
    emif.RegWr_in = 1'b0; emif.MemtoReg_in = 1'b0; emif.MemRead_in = 1'b0;
    emif.MemWrite_in = 1'b0; emif.jal_s_in = 1'b0; emif.lui_in = 1'b0; emif.halt_in = 1'b0;
    emif.dhit = 1'b0; emif.dmemload = '0;
  endtask

  task automatic test_reset();
    emif.en = 1'b1; emif.flush = 1'b0;
    emif.instr_in = $urandom; emif.pc_in = $urandom; emif.pcplusfour_in = $urandom;
    emif.alu_portOut_in = $urandom; emif.rdat2_in = $urandom; emif.imm_addr_in = 16'($urandom);
    emif.wsel_in = 5'($urandom); emif.reg_rs_in = 5'($urandom);
    emif.RegWr_in = 1'b1; emif.MemRead_in = 1'b1; emif.MemWrite_in = 1'b1; emif.halt_in = 1'b1;
    emif.dhit = 1'b1; emif.dmemload = $urandom;
    RST = 1'b1;
    step();
    step();
    tests_run++; if (emif.RegWr_out !== 1'b0) begin tests_failed++; $display("FAIL reset_regwr: got %b want 0", emif.RegWr_out); end
    tests_run++; if (emif.halt_out !== 1'b0) begin tests_failed++; $display("FAIL reset_halt: got %b want 0", emif.halt_out); end
    tests_run++; if (emif.dmemREN !== 1'b0 || emif.dmemWEN !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got REN=%b WEN=%b want 0/0", emif.dmemREN, emif.dmemWEN); end
    tests_run++; if (emif.stall_for_data !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", emif.stall_for_data); end
    tests_run++; if (emif.dmemaddr !== 32'h0 || emif.dmemstore !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got addr=%h store=%h want 0/0", emif.dmemaddr, emif.dmemstore); end
    tests_run++; if (emif.wdat_out !== 32'h0 || emif.instr_out !== 32'h0 || emif.pc_out !== 32'h0) begin tests_failed++; $display("FAIL reset_fields: got wdat=%h instr=%h pc=%h want 0", emif.wdat_out, emif.instr_out, emif.pc_out); end
    tests_run++; if (emif.wsel_out !== 5'h0 || emif.imm_addr_out !== 16'h0) begin tests_failed++; $display("FAIL reset_regs: got wsel=%h imm=%h want 0", emif.wsel_out, emif.imm_addr_out); end
    RST = 1'b0;
    clear_inputs();
    step();
  endtask

  task automatic test_alu();
    clear_inputs();
    emif.en = 1'b1; emif.RegWr_in = 1'b1; emif.alu_portOut_in = 32'h0000_0010;
    emif.instr_in = 32'h0085_1021; emif.wsel_in = 5'd2; emif.funct_in = 6'h21;
    step();
    emif.en = 1'b0;
    tests_run++; if (emif.RegWr_out !== 1'b1) begin tests_failed++; $display("FAIL alu_regwr: got %b want 1", emif.RegWr_out); end
    tests_run++; if (emif.wdat_out !== 32'h10) begin tests_failed++; $display("FAIL alu_wdat: got %h want 00000010", emif.wdat_out); end
    tests_run++; if (emif.wsel_out !== 5'd2 || emif.funct_out !== 6'h21 || emif.instr_out !== 32'h0085_1021) begin tests_failed++; $display("FAIL alu_fields: got wsel=%0d funct=%h instr=%h", emif.wsel_out, emif.funct_out, emif.instr_out); end
    tests_run++; if (emif.dmemREN !== 1'b0 || emif.stall_for_data !== 1'b0) begin tests_failed++; $display("FAIL alu_noreq: got REN=%b stall=%b want 0/0", emif.dmemREN, emif.stall_for_data); end
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++; if (emif.RegWr_out !== 1'b0) begin tests_failed++; $display("FAIL alu_once[%0d]: got %b want 0", i, emif.RegWr_out); end
    end
  endtask

  task automatic test_load_miss();
    clear_inputs();
    emif.en = 1'b1; emif.MemRead_in = 1'b1; emif.MemtoReg_in = 1'b1; emif.RegWr_in = 1'b1;
    emif.alu_portOut_in = 32'h0000_0100; emif.opcode_in = 6'h23;
    step();
    emif.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      emif.dhit = (i == 2);
      emif.dmemload = (i == 2) ? 32'hDEAD_BEEF : 32'h0;
      #1;
      tests_run++; if (emif.dmemREN !== 1'b1 || emif.dmemaddr !== 32'h100) begin tests_failed++; $display("FAIL ld_req[%0d]: got REN=%b addr=%h want 1/00000100", i, emif.dmemREN, emif.dmemaddr); end
      tests_run++; if (emif.stall_for_data !== (i < 2)) begin tests_failed++; $display("FAIL ld_stall[%0d]: got %b want %b", i, emif.stall_for_data, (i < 2)); end
      tests_run++; if (emif.RegWr_out !== (i == 2) || emif.MemtoReg_out !== (i == 2)) begin tests_failed++; $display("FAIL ld_retire[%0d]: got RegWr=%b MemtoReg=%b want %b", i, emif.RegWr_out, emif.MemtoReg_out, (i == 2)); end
      if (i == 2) begin
        tests_run++; if (emif.wdat_out !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL ld_wdat: got %h want deadbeef", emif.wdat_out); end
      end
      step();
    end
    emif.dhit = 1'b0;
    #1;
    tests_run++; if (emif.dmemREN !== 1'b0 || emif.RegWr_out !== 1'b0) begin tests_failed++; $display("FAIL ld_done: got REN=%b RegWr=%b want 0/0", emif.dmemREN, emif.RegWr_out); end
  endtask

  task automatic test_store();
    clear_inputs();
    emif.en = 1'b1; emif.MemWrite_in = 1'b1; emif.rdat2_in = 32'h1234_5678;
    emif.alu_portOut_in = 32'h0000_0200; emif.opcode_in = 6'h2B;
    step();
    emif.en = 1'b0; emif.dhit = 1'b1;
    #1;
    tests_run++; if (emif.dmemWEN !== 1'b1 || emif.dmemREN !== 1'b0) begin tests_failed++; $display("FAIL st_req: got WEN=%b REN=%b want 1/0", emif.dmemWEN, emif.dmemREN); end
    tests_run++; if (emif.dmemstore !== 32'h1234_5678 || emif.dmemaddr !== 32'h200) begin tests_failed++; $display("FAIL st_data: got store=%h addr=%h want 12345678/00000200", emif.dmemstore, emif.dmemaddr); end
    tests_run++; if (emif.stall_for_data !== 1'b0 || emif.RegWr_out !== 1'b0) begin tests_failed++; $display("FAIL st_nostall: got stall=%b RegWr=%b want 0/0", emif.stall_for_data, emif.RegWr_out); end
    step();
    emif.dhit = 1'b0;
    #1;
    tests_run++; if (emif.dmemWEN !== 1'b0) begin tests_failed++; $display("FAIL st_once: got WEN=%b want 0", emif.dmemWEN); end
  endtask

  task automatic test_flush();
    clear_inputs();
    emif.en = 1'b1; emif.flush = 1'b1; emif.RegWr_in = 1'b1; emif.MemRead_in = 1'b1;
    emif.halt_in = 1'b1; emif.alu_portOut_in = 32'h0000_0aaa;
    step();
    emif.flush = 1'b0; emif.en = 1'b0;
    tests_run++; if (emif.RegWr_out !== 1'b0 || emif.halt_out !== 1'b0) begin tests_failed++; $display("FAIL flush_bubble: got RegWr=%b halt=%b want 0/0", emif.RegWr_out, emif.halt_out); end
    tests_run++; if (emif.dmemREN !== 1'b0 || emif.stall_for_data !== 1'b0) begin tests_failed++; $display("FAIL flush_noreq: got REN=%b stall=%b want 0/0", emif.dmemREN, emif.stall_for_data); end

    // Flush while a load is outstanding must not disturb it.
    clear_inputs();
    emif.en = 1'b1; emif.MemRead_in = 1'b1; emif.RegWr_in = 1'b1; emif.alu_portOut_in = 32'h0000_0300;
    step();
    emif.flush = 1'b1; emif.MemRead_in = 1'b0; emif.RegWr_in = 1'b0;
    step();
    tests_run++; if (emif.dmemREN !== 1'b1 || emif.dmemaddr !== 32'h300 || emif.stall_for_data !== 1'b1) begin tests_failed++; $display("FAIL flush_wait: got REN=%b addr=%h stall=%b want 1/00000300/1", emif.dmemREN, emif.dmemaddr, emif.stall_for_data); end

    // dhit and ld together: old load retires, next instruction latched without a gap.
    emif.flush = 1'b0; emif.RegWr_in = 1'b1; emif.alu_portOut_in = 32'h0000_0044;
    emif.dhit = 1'b1; emif.dmemload = 32'hCAFE_F00D;
    #1;
    tests_run++; if (emif.RegWr_out !== 1'b1 || emif.wdat_out !== 32'hCAFE_F00D || emif.stall_for_data !== 1'b0) begin tests_failed++; $display("FAIL hit_ld_old: got RegWr=%b wdat=%h stall=%b want 1/cafef00d/0", emif.RegWr_out, emif.wdat_out, emif.stall_for_data); end
    step();
    emif.dhit = 1'b0; emif.en = 1'b0;
    #1;
    tests_run++; if (emif.RegWr_out !== 1'b1 || emif.wdat_out !== 32'h44 || emif.dmemREN !== 1'b0) begin tests_failed++; $display("FAIL hit_ld_new: got RegWr=%b wdat=%h REN=%b want 1/00000044/0", emif.RegWr_out, emif.wdat_out, emif.dmemREN); end
    step();
    tests_run++; if (emif.RegWr_out !== 1'b0) begin tests_failed++; $display("FAIL hit_ld_end: got RegWr=%b want 0", emif.RegWr_out); end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    emif.en = 1'b1; emif.RegWr_in = 1'b1; emif.alu_portOut_in = 32'h0000_0001; emif.wsel_in = 5'd3;
    step();
    emif.alu_portOut_in = 32'h0000_0002; emif.wsel_in = 5'd31; emif.jal_s_in = 1'b1;
    #1;
    tests_run++; if (emif.wdat_out !== 32'h1 || emif.wsel_out !== 5'd3 || emif.jal_s_out !== 1'b0) begin tests_failed++; $display("FAIL b2b_first: got wdat=%h wsel=%0d jal=%b want 00000001/3/0", emif.wdat_out, emif.wsel_out, emif.jal_s_out); end
    step();
    emif.en = 1'b0;
    tests_run++; if (emif.wdat_out !== 32'h2 || emif.wsel_out !== 5'd31 || emif.jal_s_out !== 1'b1 || emif.RegWr_out !== 1'b1) begin tests_failed++; $display("FAIL b2b_second: got wdat=%h wsel=%0d jal=%b RegWr=%b want 00000002/31/1/1", emif.wdat_out, emif.wsel_out, emif.jal_s_out, emif.RegWr_out); end
    step();
    tests_run++; if (emif.jal_s_out !== 1'b0 || emif.RegWr_out !== 1'b0) begin tests_failed++; $display("FAIL b2b_end: got jal=%b RegWr=%b want 0/0", emif.jal_s_out, emif.RegWr_out); end
  endtask

  task automatic test_reset_mid_access();
    clear_inputs();
    emif.en = 1'b1; emif.MemRead_in = 1'b1; emif.RegWr_in = 1'b1; emif.alu_portOut_in = 32'h0000_0400;
    step();
    emif.en = 1'b0;
    tests_run++; if (emif.dmemREN !== 1'b1) begin tests_failed++; $display("FAIL rstw_pre: got REN=%b want 1", emif.dmemREN); end
    RST = 1'b1;
    step();
    RST = 1'b0;
    tests_run++; if (emif.dmemREN !== 1'b0 || emif.stall_for_data !== 1'b0 || emif.RegWr_out !== 1'b0) begin tests_failed++; $display("FAIL rstw_drop: got REN=%b stall=%b RegWr=%b want 0/0/0", emif.dmemREN, emif.stall_for_data, emif.RegWr_out); end
    emif.dhit = 1'b1;
    #1;
    tests_run++; if (emif.RegWr_out !== 1'b0) begin tests_failed++; $display("FAIL rstw_noretire: got RegWr=%b want 0", emif.RegWr_out); end
    step();
    emif.dhit = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    RST = 1'b1;
    clear_inputs();
    step();
    test_reset();
    test_alu();
    test_load_miss();
    test_store();
    test_flush();
    test_back_to_back();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
